ex_stage_pipe: RTL and testbench

Parametrised, registered execute stage for the ARM pipeline. It extends the combinational EX stage with three additions:
- N-source operand forwarding covering Rn, Rm and Rs.
- An iterative MUL/MLA unit that back-pressures issue.
- An output register with a valid/ready handshake toward MEM.

It sits between the ID/EX register and the MEM stage. It reuses the existing ALU, Val2_generator and Adder blocks unchanged.

---
 rtl/ex_stage_pipe_if.sv | 52 +++++
 rtl/ex_stage_pipe.sv | 184 ++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pipe_if.sv
// ex_stage_pipe_if: issue bundle from ID/EX and result bundle toward MEM for ex_stage_pipe.
interface ex_stage_pipe_if #(
    parameter int N_FWD = 2,
    parameter int SEL_W = $clog2(N_FWD + 1)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            exe_cmd;
    logic                  is_mul;
    logic                  is_mla;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  s_upd;
    logic [31:0]           pc;
    logic [31:0]           val_rn;
    logic [31:0]           val_rm;
    logic [31:0]           val_rs;
    logic                  imm;
    logic [11:0]           shift_operand;
    logic [23:0]           signed_imm_24;
    logic                  c_in;
    logic                  v_in;
    logic [N_FWD-1:0][31:0] fwd_data;
    logic [SEL_W-1:0]      sel_rn;
    logic [SEL_W-1:0]      sel_rm;
    logic [SEL_W-1:0]      sel_rs;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           alu_result;
    logic [31:0]           val_rm_exe;
    logic [31:0]           br_addr;
    logic                  out_mem_r_en;
    logic                  out_mem_w_en;
    logic                  out_status_we;
    logic [3:0]            status;

    modport master (
        output in_valid, exe_cmd, is_mul, is_mla, mem_r_en, mem_w_en, s_upd, pc,
               val_rn, val_rm, val_rs, imm, shift_operand, signed_imm_24, c_in, v_in,
               fwd_data, sel_rn, sel_rm, sel_rs, out_ready,
        input  in_ready, out_valid, alu_result, val_rm_exe, br_addr, out_mem_r_en,
               out_mem_w_en, out_status_we, status
    );

    modport slave (
        input  in_valid, exe_cmd, is_mul, is_mla, mem_r_en, mem_w_en, s_upd, pc,
               val_rn, val_rm, val_rs, imm, shift_operand, signed_imm_24, c_in, v_in,
               fwd_data, sel_rn, sel_rm, sel_rs, out_ready,
        output in_ready, out_valid, alu_result, val_rm_exe, br_addr, out_mem_r_en,
               out_mem_w_en, out_status_we, status
    );
endinterface

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: registered ARM execute stage with operand forwarding and a valid/ready
// output register. Defining EX_MUL_EN builds the iterative MUL/MLA unit and Rs forwarding.
module ex_stage_pipe #(
    parameter int MUL_BITS_PER_CYCLE = 4,
    parameter int N_FWD              = 2
) (
    input  logic           clk,
    input  logic           reset,
    ex_stage_pipe_if.slave bus
);
    localparam int SEL_W = $clog2(N_FWD + 1);

    localparam logic [3:0] CMD_MOV = 4'b0001, CMD_MVN = 4'b1001, CMD_ADD = 4'b0010,
                           CMD_ADC = 4'b0011, CMD_SUB = 4'b0100, CMD_SBC = 4'b0101,
                           CMD_AND = 4'b0110, CMD_ORR = 4'b0111, CMD_EOR = 4'b1000;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] val_rm_exe;
        logic [31:0] br_addr;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        status_we;
        logic [3:0]  status;
    } res_t;

    // Out-of-range selects fall through to the register-file value.
    function automatic logic [31:0] fwd_mux(input logic [SEL_W-1:0] sel, input logic [31:0] rf,
                                            input logic [N_FWD-1:0][31:0] src);
        fwd_mux = rf;
        for (int i = 0; i < N_FWD; i++)
            if (sel == SEL_W'(i + 1)) fwd_mux = src[i];
    endfunction

    logic [31:0] rn, rm, val2, imm_x, alu_res, br_addr;
    logic [32:0] sum;
    logic [4:0]  sh_amt;
    logic        c_out, v_out, carry_in;
    res_t        alu_pkt, out_d, out_q;
    logic        out_valid_q, load, accept;

    assign rn      = fwd_mux(bus.sel_rn, bus.val_rn, bus.fwd_data);
    assign rm      = fwd_mux(bus.sel_rm, bus.val_rm, bus.fwd_data);
    assign imm_x   = {24'd0, bus.shift_operand[7:0]};
    assign sh_amt  = bus.shift_operand[11:7];
    assign br_addr = bus.pc + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};

    always_comb begin
        val2 = rm;
        if (bus.mem_r_en || bus.mem_w_en)
            val2 = {20'd0, bus.shift_operand};
        else if (bus.imm)
            val2 = 32'({imm_x, imm_x} >> {bus.shift_operand[11:8], 1'b0});
        else
            case (bus.shift_operand[6:5])
                2'b00:   val2 = rm << sh_amt;
                2'b01:   val2 = rm >> sh_amt;
                2'b10:   val2 = 32'($signed(rm) >>> sh_amt);
                default: val2 = 32'({rm, rm} >> sh_amt);
            endcase
    end

    // Subtraction is rn + ~val2 + carry, so C is ARM's not-borrow.
    always_comb begin
        alu_res  = 32'd0;
        c_out    = bus.c_in;
        v_out    = bus.v_in;
        sum      = 33'd0;
        carry_in = 1'b0;
        case (bus.exe_cmd)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_ADD, CMD_ADC: begin
                carry_in = (bus.exe_cmd == CMD_ADC) && bus.c_in;
                sum      = {1'b0, rn} + {1'b0, val2} + {32'd0, carry_in};
                alu_res  = sum[31:0];
                c_out    = sum[32];
                v_out    = (rn[31] == val2[31]) && (alu_res[31] != rn[31]);
            end
            CMD_SUB, CMD_SBC: begin
                carry_in = (bus.exe_cmd == CMD_SUB) || bus.c_in;
                sum      = {1'b0, rn} + {1'b0, ~val2} + {32'd0, carry_in};
                alu_res  = sum[31:0];
                c_out    = sum[32];
                v_out    = (rn[31] != val2[31]) && (alu_res[31] != rn[31]);
            end
            CMD_AND: alu_res = rn & val2;
            CMD_ORR: alu_res = rn | val2;
            CMD_EOR: alu_res = rn ^ val2;
            default: alu_res = 32'd0;
        endcase
    end

    assign alu_pkt = '{alu_result: alu_res, val_rm_exe: rm, br_addr: br_addr,
                       mem_r_en: bus.mem_r_en, mem_w_en: bus.mem_w_en, status_we: bus.s_upd,
                       status: {c_out, v_out, alu_res[31], alu_res == 32'd0}};

`ifdef EX_MUL_EN
    localparam int B     = MUL_BITS_PER_CYCLE;
    localparam int STEPS = 32 / B;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [0:0] S_IDLE = 1'b0, S_MUL = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      acc, mcand, mplier, rm_lat, rs, acc_next;
    logic             c_lat, v_lat, su_lat, mul_op, mul_done;
    res_t             mul_pkt;

    assign rs           = fwd_mux(bus.sel_rs, bus.val_rs, bus.fwd_data);
    assign mul_op       = bus.is_mul || bus.is_mla;
    assign bus.in_ready = (state == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign acc_next     = acc + mcand * 32'(mplier[B-1:0]);
    assign mul_done     = (state == S_MUL) && (cnt == CNT_W'(1));
    assign load         = (accept && !mul_op) || mul_done;
    assign mul_pkt      = '{alu_result: acc_next, val_rm_exe: rm_lat, br_addr: 32'd0,
                            mem_r_en: 1'b0, mem_w_en: 1'b0, status_we: su_lat,
                            status: {c_lat, v_lat, acc_next[31], acc_next == 32'd0}};
    assign out_d        = mul_done ? mul_pkt : alu_pkt;

    // Operands and flags are captured at accept; the issue side is free to change afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rm_lat <= '0;
            c_lat  <= 1'b0;
            v_lat  <= 1'b0;
            su_lat <= 1'b0;
        end else if (state == S_IDLE) begin
            if (accept && mul_op) begin
                state  <= S_MUL;
                acc    <= bus.is_mla ? rn : 32'd0;
                mcand  <= rm;
                mplier <= rs;
                rm_lat <= rm;
                c_lat  <= bus.c_in;
                v_lat  <= bus.v_in;
                su_lat <= bus.s_upd;
                cnt    <= CNT_W'(STEPS);
            end
        end else begin
            acc    <= acc_next;
            mcand  <= mcand << B;
            mplier <= mplier >> B;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= S_IDLE;
        end
    end
`else
    logic unused_mul;
    assign unused_mul   = ^{bus.is_mul, bus.is_mla, bus.val_rs, bus.sel_rs};
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign load         = accept;
    assign out_d        = alu_pkt;
`endif

    // A load in the same cycle as a drain keeps the register valid with the new data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_q       <= out_d;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.alu_result    = out_q.alu_result;
    assign bus.val_rm_exe    = out_q.val_rm_exe;
    assign bus.br_addr       = out_q.br_addr;
    assign bus.out_mem_r_en  = out_q.mem_r_en;
    assign bus.out_mem_w_en  = out_q.mem_w_en;
    assign bus.out_status_we = out_q.status_we;
    assign bus.status        = out_q.status;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: vector table, randomized ALU/MUL traffic against a behavioural model,
// and hand sequences for back-pressure and reset during a multiply.
module tb_ex_stage_pipe;
    localparam int N_FWD = 2;
    localparam int B     = 4;
    localparam int STEPS = 32 / B;
    localparam longint MAXS = 64'sh7FFF_FFFF;
    localparam longint MINS = -64'sh8000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ex_stage_pipe_if #(.N_FWD(N_FWD)) bus ();
    ex_stage_pipe #(.MUL_BITS_PER_CYCLE(B), .N_FWD(N_FWD)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        bit [3:0]  cmd;
        bit [31:0] rn, rm, rs, pc;
        bit [1:0]  srn, srm, srs;
        bit        imm, c, v, mr, mw, su, mul, mla;
        bit [11:0] shop;
        bit [23:0] off;
    } in_t;

    typedef struct {
        in_t       i;
        bit [31:0] res;
        bit [3:0]  st;
        bit [31:0] br;
    } vec_t;

    int        n_chk = 0;
    int        n_fail = 0;
    bit [31:0] fwd [N_FWD];
    vec_t      tbl [$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit [31:0] pick(bit [1:0] sel, bit [31:0] rf);
        if (sel >= 2'd1 && int'(sel) <= N_FWD) return fwd[int'(sel) - 1];
        return rf;
    endfunction

    // Shifter operand, one bit position per step.
    function automatic bit [31:0] m_val2(in_t x, bit [31:0] r);
        bit [31:0] t;
        if (x.mr || x.mw) return {20'd0, x.shop};
        if (x.imm) begin
            t = {24'd0, x.shop[7:0]};
            for (int k = 0; k < 2 * int'(x.shop[11:8]); k++) t = {t[0], t[31:1]};
            return t;
        end
        t = r;
        for (int k = 0; k < int'(x.shop[11:7]); k++)
            case (x.shop[6:5])
                2'd0: t = t << 1;
                2'd1: t = t >> 1;
                2'd2: t = {t[31], t[31:1]};
                default: t = {t[0], t[31:1]};
            endcase
        return t;
    endfunction

    function automatic void model(in_t x, output bit [31:0] res, output bit [3:0] st);
        bit [31:0] a, b;
        longint    u, s, ci;
        bit        c, v;
        a = pick(x.srn, x.rn);
        b = m_val2(x, pick(x.srm, x.rm));
        c = x.c; v = x.v; res = 0;
        case (x.cmd)
            4'b0001: res = b;
            4'b1001: res = ~b;
            4'b0010, 4'b0011: begin
                ci = (x.cmd == 4'b0011) ? longint'(x.c) : 0;
                u = longint'(a) + longint'(b) + ci;
                s = longint'(signed'(a)) + longint'(signed'(b)) + ci;
                res = u[31:0]; c = (u > 64'sh0_FFFF_FFFF); v = (s > MAXS) || (s < MINS);
            end
            4'b0100, 4'b0101: begin
                ci = (x.cmd == 4'b0101) ? longint'(!x.c) : 0;
                u = longint'(a) - longint'(b) - ci;
                s = longint'(signed'(a)) - longint'(signed'(b)) - ci;
                res = u[31:0]; c = (u >= 0); v = (s > MAXS) || (s < MINS);
            end
            4'b0110: res = a & b;
            4'b0111: res = a | b;
            4'b1000: res = a ^ b;
            default: res = 0;
        endcase
        st = {c, v, res[31], res == 32'd0};
    endfunction

    function automatic in_t mk(bit [3:0] cmd, bit [31:0] rn, bit [31:0] rm, bit [11:0] shop);
        in_t x;
        x = '{default: '0};
        x.cmd = cmd; x.rn = rn; x.rm = rm; x.shop = shop;
        return x;
    endfunction

    function automatic void add(in_t x, bit [31:0] res, bit [3:0] st, bit [31:0] br);
        vec_t e;
        e.i = x; e.res = res; e.st = st; e.br = br;
        tbl.push_back(e);
    endfunction

    function automatic in_t rnd_in();
        in_t x;
        x = '{default: '0};
        case ($urandom_range(0, 8))
            0: x.cmd = 4'b0001; 1: x.cmd = 4'b1001; 2: x.cmd = 4'b0010;
            3: x.cmd = 4'b0011; 4: x.cmd = 4'b0100; 5: x.cmd = 4'b0101;
            6: x.cmd = 4'b0110; 7: x.cmd = 4'b0111; default: x.cmd = 4'b1000;
        endcase
        x.rn = $urandom; x.rm = $urandom; x.rs = $urandom; x.pc = $urandom;
        x.srn = 2'($urandom_range(0, 3)); x.srm = 2'($urandom_range(0, 3));
        x.srs = 2'($urandom_range(0, 3));
        x.imm = 1'($urandom); x.c = 1'($urandom); x.v = 1'($urandom); x.su = 1'($urandom);
        x.mr = ($urandom_range(0, 5) == 0); x.mw = ($urandom_range(0, 5) == 0);
        x.shop = 12'($urandom); x.off = 24'($urandom);
        if ($urandom_range(0, 4) == 0) begin x.rm = x.rn; x.srm = x.srn; x.shop[11:7] = 5'd0; end
        return x;
    endfunction

    task automatic drive(in_t x);
        bus.exe_cmd = x.cmd; bus.is_mul = x.mul; bus.is_mla = x.mla;
        bus.mem_r_en = x.mr; bus.mem_w_en = x.mw; bus.s_upd = x.su; bus.pc = x.pc;
        bus.val_rn = x.rn; bus.val_rm = x.rm; bus.val_rs = x.rs; bus.imm = x.imm;
        bus.shift_operand = x.shop; bus.signed_imm_24 = x.off; bus.c_in = x.c; bus.v_in = x.v;
        bus.sel_rn = x.srn; bus.sel_rm = x.srm; bus.sel_rs = x.srs;
        for (int k = 0; k < N_FWD; k++) bus.fwd_data[k] = fwd[k];
        bus.in_valid = 1'b1;
    endtask

    task automatic issue(string nm, in_t x);
        int t = 0;
        @(negedge clk);
        drive(x);
        #1;
        while (!bus.in_ready && t < 50) begin @(negedge clk); #1; t++; end
        if (!bus.in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL %s issue: in_ready got 0 expected 1 within 50 cycles", nm);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_alu(string nm, in_t x, bit [31:0] res, bit [3:0] st, bit [31:0] br);
        chk({nm, " out_valid"}, bus.out_valid, 1);
        chk({nm, " alu_result"}, bus.alu_result, res);
        chk({nm, " status"}, bus.status, st);
        chk({nm, " br_addr"}, bus.br_addr, br);
        chk({nm, " val_rm_exe"}, bus.val_rm_exe, pick(x.srm, x.rm));
        chk({nm, " flags"}, {bus.out_mem_r_en, bus.out_mem_w_en, bus.out_status_we},
            {x.mr, x.mw, x.su});
        chk({nm, " in_ready"}, bus.in_ready, 1);
    endtask

`ifdef EX_MUL_EN
    task automatic run_mul(string nm, in_t x, bit [31:0] res, bit [3:0] st);
        int stall = 0;
        issue(nm, x);
        for (int k = 0; k < N_FWD; k++) bus.fwd_data[k] = $urandom;
        bus.val_rn = $urandom; bus.val_rm = $urandom; bus.val_rs = $urandom;
        bus.sel_rn = 2'($urandom); bus.sel_rm = 2'($urandom); bus.sel_rs = 2'($urandom);
        bus.c_in = ~x.c; bus.v_in = ~x.v; bus.s_upd = ~x.su;
        #1;
        while (!bus.in_ready && stall < 100) begin stall++; @(negedge clk); #1; end
        chk({nm, " stall"}, stall, STEPS);
        chk({nm, " out_valid"}, bus.out_valid, 1);
        chk({nm, " alu_result"}, bus.alu_result, res);
        chk({nm, " status"}, bus.status, st);
        chk({nm, " val_rm_exe"}, bus.val_rm_exe, pick(x.srm, x.rm));
        chk({nm, " flags"}, {bus.out_mem_r_en, bus.out_mem_w_en, bus.out_status_we},
            {2'b00, x.su});
    endtask
`endif

    initial begin
        in_t       x;
        bit [31:0] er;
        bit [3:0]  es;
        bit [63:0] p;
        bit        seen;

        fwd[0] = 32'h55; fwd[1] = 32'h100;
        x = mk(4'b0000, 0, 0, 0);
        drive(x);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset alu_result", bus.alu_result, 0);
        chk("reset status", {bus.status, bus.out_status_we, bus.out_mem_r_en, bus.out_mem_w_en}, 0);
        chk("reset br_addr", bus.br_addr, 0);
        reset = 1'b0;
        #1;
        chk("post-reset in_ready", bus.in_ready, 1);

        x = mk(4'b0010, 5, 7, 0); x.su = 1;            add(x, 12, 4'b0000, 0);
        x = mk(4'b0010, 32'h999, 1, 0); x.srn = 2;
        x.pc = 32'h2000; x.off = 24'h000004;            add(x, 32'h101, 4'b0000, 32'h2010);
        x = mk(4'b0010, 32'h20, 1, 0); x.srn = 3;       add(x, 32'h21, 4'b0000, 0);
        x = mk(4'b0001, 0, 0, 0); x.c = 1;
        x.pc = 32'h1000; x.off = 24'hFFFFFE;            add(x, 0, 4'b1001, 32'h0FF8);
        x = mk(4'b0100, 5, 5, 0);                       add(x, 0, 4'b1001, 0);
        x = mk(4'b0100, 0, 1, 0);                       add(x, 32'hFFFF_FFFF, 4'b0010, 0);
        x = mk(4'b0010, 32'h7FFF_FFFF, 1, 0);           add(x, 32'h8000_0000, 4'b0110, 0);
        x = mk(4'b0010, 32'hFFFF_FFFF, 1, 0);           add(x, 0, 4'b1001, 0);
        x = mk(4'b0001, 0, 0, 12'h4FF); x.imm = 1;      add(x, 32'hFF00_0000, 4'b0010, 0);
        x = mk(4'b0010, 32'h100, 0, 12'hABC); x.mr = 1; add(x, 32'hBBC, 4'b0000, 0);
        x = mk(4'b0001, 0, 32'h8000_0000, 12'h220);     add(x, 32'h0800_0000, 4'b0000, 0);
        x = mk(4'b0001, 0, 32'h8000_0000, 12'h240);     add(x, 32'hF800_0000, 4'b0010, 0);
        x = mk(4'b1000, 32'hFF, 32'h1234, 0); x.srm = 1;
        x.c = 1; x.v = 1;                               add(x, 32'hAA, 4'b1100, 0);
        x = mk(4'b0011, 1, 2, 0); x.c = 1;              add(x, 4, 4'b0000, 0);
        x = mk(4'b0101, 5, 3, 0);                       add(x, 1, 4'b1000, 0);
        x = mk(4'b0001, 0, 32'hF1, 12'h260);            add(x, 32'h1000_000F, 4'b0000, 0);
        x = mk(4'b0010, 32'h200, 0, 12'h010); x.mw = 1; add(x, 32'h210, 4'b0000, 0);

        foreach (tbl[n]) begin
            issue($sformatf("vec%0d", n), tbl[n].i);
            check_alu($sformatf("vec%0d", n), tbl[n].i, tbl[n].res, tbl[n].st, tbl[n].br);
        end

        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < N_FWD; k++) fwd[k] = $urandom;
            x = rnd_in();
            model(x, er, es);
            issue($sformatf("rnd%0d", n), x);
            check_alu($sformatf("rnd%0d", n), x, er, es, x.pc + {{6{x.off[23]}}, x.off, 2'b00});
        end
        fwd[0] = 32'h55; fwd[1] = 32'h100;

        // Held result under back-pressure, then drain and load at the same edge.
        @(negedge clk);
        bus.out_ready = 1'b0;
        issue("bp_a", mk(4'b0010, 32'h10, 32'h20, 0));
        #1;
        for (int n = 0; n < 3; n++) begin
            chk("bp hold valid", bus.out_valid, 1);
            chk("bp hold in_ready", bus.in_ready, 0);
            chk("bp hold result", bus.alu_result, 32'h30);
            @(negedge clk);
            #1;
        end
        drive(mk(4'b0100, 32'h50, 32'h8, 0));
        bus.out_ready = 1'b1;
        #1;
        chk("bp release in_ready", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp swap valid", bus.out_valid, 1);
        chk("bp swap result", bus.alu_result, 32'h48);
        @(negedge clk);
        chk("bp drained", bus.out_valid, 0);

`ifdef EX_MUL_EN
        x = mk(4'b0000, 0, 32'hFFFF_FFFF, 0); x.rs = 3; x.mul = 1; x.su = 1;
        run_mul("mul_neg", x, 32'hFFFF_FFFD, 4'b0010);
        x = mk(4'b0000, 0, 32'h8000_0000, 0); x.rs = 2; x.mla = 1; x.c = 1;
        run_mul("mla_wrap", x, 0, 4'b1001);
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < N_FWD; k++) fwd[k] = $urandom;
            x = rnd_in();
            x.mr = 0; x.mw = 0;
            if ($urandom_range(0, 1) == 1) x.mla = 1; else x.mul = 1;
            p = 64'(pick(x.srm, x.rm)) * 64'(pick(x.srs, x.rs)) + (x.mla ? 64'(pick(x.srn, x.rn)) : 64'd0);
            er = p[31:0];
            run_mul($sformatf("mulrnd%0d", n), x, er, {x.c, x.v, er[31], er == 32'd0});
        end
        fwd[0] = 32'h55; fwd[1] = 32'h100;
        @(negedge clk);
        x = mk(4'b0000, 7, 32'h8000_0000, 0); x.rs = 2; x.mla = 1;
        issue("mul_rst", x);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mul_rst out_valid", bus.out_valid, 0);
        chk("mul_rst in_ready", bus.in_ready, 1);
        seen = 0;
        for (int n = 0; n < STEPS + 4; n++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        chk("mul_rst no result", seen, 0);
`else
        x = mk(4'b0010, 3, 4, 0); x.mul = 1; x.mla = 1; x.rs = 32'h9; x.srs = 1;
        issue("mul_ignored", x);
        check_alu("mul_ignored", x, 7, 4'b0000, 0);
        @(negedge clk);
        chk("mul_ignored drained", bus.out_valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
        $fatal(1);
    end
endmodule
